// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock sequencer.
// Holds the sequencer state encoding and the reference-clock cycle counts.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_e;

    // Defaults assume a 50 MHz reference clock.
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 1_000_000;
    localparam int DEF_STABLE_CYCLES  = 4096;
    localparam int DEF_CNT_W          = 20;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single-bit level crossing into clk.
// Ports: clk, rst (async, active-high), d_i (async level), q_o (synchronised).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives the PLL reset, waits for a stable lock and releases the core reset.
// Ports: clk/rst in; locked in (async); pll_rst, sys_reset, ready,
// relock_count[7:0], timeout_err out. All outputs are registered.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    // Reload values: entry cycle plus N-1 decrements gives N cycles dwell.
    localparam logic [CNT_W-1:0] PRST_LD = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOUT_LD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LD = CNT_W'(STABLE_CYCLES - 1);

    logic             lk;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pll_rst_q;
    logic             sys_reset_q;
    logic             ready_q;
    logic [7:0]       relock_q;
    logic             terr_q;
    logic             cnt_zero;

    sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (locked),
        .q_o (lk)
    );

    assign cnt_zero = (cnt_q == '0);

    // Outputs are set on the edge that enters a state, so they track state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= PRST_LD;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            relock_q    <= 8'd0;
            terr_q      <= 1'b0;
        end else begin
            unique case (state_q)
                PLL_RST: begin
                    if (cnt_zero) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= TOUT_LD;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock is tested first so it wins over an expiring timeout.
                    if (lk) begin
                        state_q <= STABILIZE;
                        cnt_q   <= STAB_LD;
                    end else if (cnt_zero) begin
                        state_q   <= PLL_RST;
                        cnt_q     <= PRST_LD;
                        pll_rst_q <= 1'b1;
                        terr_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STABILIZE: begin
                    // A drop restarts the lock wait without re-resetting the PLL.
                    if (!lk) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= TOUT_LD;
                    end else if (cnt_zero) begin
                        state_q     <= RUN;
                        sys_reset_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_q     <= PLL_RST;
                        cnt_q       <= PRST_LD;
                        pll_rst_q   <= 1'b1;
                        sys_reset_q <= 1'b1;
                        ready_q     <= 1'b0;
                        if (relock_q != 8'hFF) begin
                            relock_q <= relock_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= PLL_RST;
                    cnt_q       <= PRST_LD;
                    pll_rst_q   <= 1'b1;
                    sys_reset_q <= 1'b1;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_reset    = sys_reset_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
    assign timeout_err  = terr_q;

endmodule
